// File: rtl/issue_queue_data.sv
// Four-entry issue queue holding operand data, wakeup state and prediction info per entry.
// Dispatch captures into the lowest free slot; writeback wakes pending sources; flush drops everything.
module issue_queue_data (
  input  logic          clk,
  input  logic          resetn,
  input  logic          bco_valid,
  input  logic          d_valid,
  output logic          d_ready,
  input  logic [3:0]    d_src0_rob,
  input  logic          d_src0_rdy,
  input  logic [31:0]   d_src0_value,
  input  logic [3:0]    d_src1_rob,
  input  logic          d_src1_rdy,
  input  logic [31:0]   d_src1_value,
  input  logic [3:0]    d_dst_rob,
  input  logic          d_branch,
  input  logic          d_load,
  input  logic          d_store,
  input  logic          d_pipe_alu,
  input  logic          d_pipe_mul,
  input  logic          d_pipe_mem,
  input  logic          d_pipe_bru,
  input  logic [1:0]    d_bp_pattern,
  input  logic          d_bp_taken,
  input  logic          d_bp_hit,
  input  logic [31:0]   d_bp_target,
  input  logic          wb_valid,
  input  logic [3:0]    wb_rob,
  input  logic [31:0]   wb_value,
  input  logic [3:0]    i_en,
  output logic [3:0]    o_valid,
  output logic [15:0]   o_src0_rob,
  output logic [3:0]    o_src0_rdy,
  output logic [127:0]  o_src0_value,
  output logic [15:0]   o_src1_rob,
  output logic [3:0]    o_src1_rdy,
  output logic [127:0]  o_src1_value,
  output logic [15:0]   o_dst_rob,
  output logic [3:0]    o_branch,
  output logic [3:0]    o_load,
  output logic [3:0]    o_store,
  output logic [3:0]    o_pipe_alu,
  output logic [3:0]    o_pipe_mul,
  output logic [3:0]    o_pipe_mem,
  output logic [3:0]    o_pipe_bru,
  output logic [7:0]    o_bp_pattern,
  output logic [3:0]    o_bp_taken,
  output logic [3:0]    o_bp_hit,
  output logic [127:0]  o_bp_target,
  output logic [2:0]    o_count
);

  logic       dispatch;
  logic       release_any;
  logic [1:0] alloc_idx;
  logic [32:0] cap0;
  logic [32:0] cap1;

  // Operand capture at dispatch: {rdy, value}, with same-cycle writeback bypass.
  function automatic logic [32:0] capture(input logic [3:0] rob, input logic rdy,
                                          input logic [31:0] value);
    if (rdy)
      return {1'b1, value};
    else if (wb_valid && (wb_rob == rob))
      return {1'b1, wb_value};
    else
      return 33'd0;
  endfunction

  assign d_ready     = (o_count < 3'd4) && !bco_valid;
  assign dispatch    = d_valid && d_ready;
  assign release_any = |(i_en & o_valid);
  assign cap0        = capture(d_src0_rob, d_src0_rdy, d_src0_value);
  assign cap1        = capture(d_src1_rob, d_src1_rdy, d_src1_value);

  // Allocation sees pre-release occupancy, so a slot freed this cycle is not reused until next.
  always_comb begin
    alloc_idx = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (!o_valid[k]) alloc_idx = k[1:0];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      o_valid      <= '0;
      o_src0_rob   <= '0;
      o_src0_rdy   <= '0;
      o_src0_value <= '0;
      o_src1_rob   <= '0;
      o_src1_rdy   <= '0;
      o_src1_value <= '0;
      o_dst_rob    <= '0;
      o_branch     <= '0;
      o_load       <= '0;
      o_store      <= '0;
      o_pipe_alu   <= '0;
      o_pipe_mul   <= '0;
      o_pipe_mem   <= '0;
      o_pipe_bru   <= '0;
      o_bp_pattern <= '0;
      o_bp_taken   <= '0;
      o_bp_hit     <= '0;
      o_bp_target  <= '0;
      o_count      <= '0;
    end else if (bco_valid) begin
      o_valid <= '0;
      o_count <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (o_valid[k]) begin
          if (i_en[k]) begin
            o_valid[k] <= 1'b0;
          end else if (wb_valid) begin
            if (!o_src0_rdy[k] && (o_src0_rob[k*4 +: 4] == wb_rob)) begin
              o_src0_rdy[k]          <= 1'b1;
              o_src0_value[k*32 +: 32] <= wb_value;
            end
            if (!o_src1_rdy[k] && (o_src1_rob[k*4 +: 4] == wb_rob)) begin
              o_src1_rdy[k]          <= 1'b1;
              o_src1_value[k*32 +: 32] <= wb_value;
            end
          end
        end
      end
      // The allocated slot is invalid, so it never collides with release/wakeup above.
      if (dispatch) begin
        o_valid[alloc_idx]               <= 1'b1;
        o_src0_rob[alloc_idx*4 +: 4]     <= d_src0_rob;
        o_src0_rdy[alloc_idx]            <= cap0[32];
        o_src0_value[alloc_idx*32 +: 32] <= cap0[31:0];
        o_src1_rob[alloc_idx*4 +: 4]     <= d_src1_rob;
        o_src1_rdy[alloc_idx]            <= cap1[32];
        o_src1_value[alloc_idx*32 +: 32] <= cap1[31:0];
        o_dst_rob[alloc_idx*4 +: 4]      <= d_dst_rob;
        o_branch[alloc_idx]              <= d_branch;
        o_load[alloc_idx]                <= d_load;
        o_store[alloc_idx]               <= d_store;
        o_pipe_alu[alloc_idx]            <= d_pipe_alu;
        o_pipe_mul[alloc_idx]            <= d_pipe_mul;
        o_pipe_mem[alloc_idx]            <= d_pipe_mem;
        o_pipe_bru[alloc_idx]            <= d_pipe_bru;
        o_bp_pattern[alloc_idx*2 +: 2]   <= d_bp_pattern;
        o_bp_taken[alloc_idx]            <= d_bp_taken;
        o_bp_hit[alloc_idx]              <= d_bp_hit;
        o_bp_target[alloc_idx*32 +: 32]  <= d_bp_target;
      end
      o_count <= o_count + {2'b00, dispatch} - {2'b00, release_any};
    end
  end

endmodule

// File: doc/issue_queue_data.md
ISSUE_QUEUE_DATA -- requirements
Module: issue_queue_data

Interface
REQ-001 SHALL have no parameters: 4 entries, 4-bit ROB tags, 32-bit values, all fixed.
REQ-002 SHALL have a single clock and an asynchronous, active-low reset (ports below).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 bco_valid  in  1  branch-commit flush; clears the whole queue.
REQ-006 d_valid / d_ready  in / out  1 / 1  dispatch handshake; transfer when both are 1.
REQ-007 d_src0_rob, d_src0_rdy, d_src0_value  in  4 / 1 / 32  source-0 tag, ready flag, operand value.
REQ-008 d_src1_rob, d_src1_rdy, d_src1_value  in  4 / 1 / 32  source-1 tag, ready flag, operand value.
REQ-009 d_dst_rob, d_branch, d_load, d_store  in  4 / 1 / 1 / 1  destination tag and instruction class.
REQ-010 d_pipe_alu, d_pipe_mul, d_pipe_mem, d_pipe_bru  in  1 each  target pipe (one-hot).
REQ-011 d_bp_pattern, d_bp_taken, d_bp_hit, d_bp_target  in  2 / 1 / 1 / 32  branch-prediction info.
REQ-012 wb_valid, wb_rob, wb_value  in  1 / 4 / 32  writeback wakeup bus.
REQ-013 i_en  in  4  per-entry issue enable from the picker (one-hot or zero).
REQ-014 o_valid  out  4  per-entry occupied flag.
REQ-015 o_src0_rob, o_src0_rdy, o_src0_value  out  16 / 4 / 128  entry k occupies slice [k*w +: w].
REQ-016 o_src1_rob, o_src1_rdy, o_src1_value  out  16 / 4 / 128  same slicing as REQ-015.
REQ-017 o_dst_rob, o_branch, o_load, o_store, o_pipe_alu/mul/mem/bru  out  16 / 4 each  per-entry fields.
REQ-018 o_bp_pattern, o_bp_taken, o_bp_hit, o_bp_target  out  8 / 4 / 4 / 128  per-entry prediction fields.
REQ-019 o_count  out  3  number of occupied entries, 0..4.

Function
REQ-020 All o_* entry outputs SHALL come directly from entry registers; there SHALL be no combinational path from inputs to entry outputs.
REQ-021 d_ready SHALL be 1 iff (o_count < 4) and bco_valid = 0; d_ready SHALL NOT depend on d_valid.
REQ-022 On a dispatch transfer, the queue SHALL write the lowest-index entry with o_valid = 0; the entry becomes visible (o_valid = 1) the next cycle.
REQ-023 An entry released by i_en in cycle N SHALL NOT be allocatable until cycle N+1.
REQ-024 Source capture at dispatch: if d_srcX_rdy = 1, store d_srcX_value with rdy = 1; else if wb_valid and wb_rob = d_srcX_rob in the same cycle, store wb_value with rdy = 1; else store rdy = 0 and value = 0.
REQ-025 Wakeup: for each valid entry whose srcX_rdy = 0 and whose srcX_rob = wb_rob while wb_valid = 1, set rdy = 1 and latch wb_value; the update is visible the next cycle.
REQ-026 Entries with srcX_rdy = 1 SHALL ignore writeback; src0 and src1 of one entry SHALL both wake up if both tags match.
REQ-027 i_en[k] = 1 with o_valid[k] = 1 SHALL clear o_valid[k] next cycle; i_en[k] on an invalid entry SHALL be ignored.
REQ-028 Release and wakeup of the same entry in the same cycle: release wins; the entry becomes invalid.
REQ-029 bco_valid = 1 SHALL clear all o_valid next cycle and discard any dispatch that cycle; flush overrides release and wakeup.
REQ-030 o_count SHALL update each cycle by +1 on dispatch, -1 on a valid release, and net 0 when both occur; it SHALL be set to 0 on flush; it SHALL never exceed 4 or wrap.
REQ-031 Fields of invalid entries SHALL hold their last values; consumers SHALL qualify every field with o_valid.

Reset
REQ-032 resetn = 0 SHALL immediately force o_valid = 0, all rdy = 0, all value/tag/class/bp fields = 0, and o_count = 0.
REQ-033 After reset deasserts, d_ready SHALL be 1 in the first cycle in which bco_valid = 0.
REQ-034 Reset asserted mid-operation SHALL discard all entries with no partial state remaining.

Verification
REQ-035 Fill: dispatch 4 instructions back-to-back with both sources ready -> o_valid = 4'b1111, o_count = 4, d_ready = 0, entry order 0..3.
REQ-036 Wakeup: entry 2 has src1_rob = 5, rdy = 0; drive wb_valid = 1, wb_rob = 5, wb_value = 0xDEADBEEF -> next cycle o_src1_rdy[2] = 1 and o_src1_value[95:64] = 0xDEADBEEF; other entries unchanged.
REQ-037 Dispatch bypass: dispatch src0_rob = 3, rdy = 0, while wb_rob = 3, wb_value = 0x1234 -> the entry shows src0_rdy = 1 and value 0x1234.
REQ-038 Full + release: queue full, i_en = 4'b0100 with d_valid = 1 -> next cycle o_valid = 4'b1011 and o_count = 3, no dispatch that cycle; the following cycle a dispatch fills entry 2.
REQ-039 Simultaneous events: entry 1 wakeup and i_en = 4'b0010 in the same cycle -> o_valid[1] = 0; bco_valid with d_valid = 1 -> o_valid = 0 and o_count = 0 next cycle.
REQ-040 Async reset: assert resetn = 0 between clock edges with 3 entries valid -> o_valid = 0 and o_count = 0 without waiting for a clock edge.
